inst_fetch: RTL

//  Fetch stage of the 9-bit core: owns the program counter, drives the instruction ROM's

---
 rtl/core_pkg.sv | 26 ++
 rtl/inst_fetch_pc_next.sv | 41 ++++
 rtl/inst_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the 9-bit core front end.
// Holds fetch FSM states, next-pc select codes and the branch-offset sign extender.
package core_pkg;

    localparam int IW_DEF = 16;
    localparam int DW_DEF = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_START,
        PC_INC,
        PC_TGT
    } pc_sel_t;

    // Sign-extend the 8-bit relative branch offset to the default PC width.
    function automatic logic [IW_DEF-1:0] sext_off(input logic [7:0] off);
        return {{(IW_DEF-8){off[7]}}, off};
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
// Ports: sel (pc_sel_t code), pc, inst_pc, br_abs, br_offset, jmp_target -> pc_nxt.
module pc_next
    import core_pkg::*;
#(
    parameter int              IW         = IW_DEF,
    parameter logic [IW-1:0]   START_ADDR = '0
) (
    input  logic [1:0]    sel,
    input  logic [IW-1:0] pc,
    input  logic [IW-1:0] inst_pc,
    input  logic          br_abs,
    input  logic [7:0]    br_offset,
    input  logic [IW-1:0] jmp_target,
    output logic [IW-1:0] pc_nxt
);

    logic [IW-1:0] off;
    logic [IW-1:0] target;

    if (IW == IW_DEF) begin : g_pkg_sext
        assign off = sext_off(br_offset);
    end else begin : g_gen_sext
        assign off = {{(IW-8){br_offset[7]}}, br_offset};
    end

    // Relative targets are taken from the instruction being redirected,
    // not from pc, which has already moved one ahead.
    assign target = br_abs ? jmp_target : inst_pc + off;

    always_comb begin
        pc_nxt = pc;
        case (pc_sel_t'(sel))
            PC_START: pc_nxt = START_ADDR;
            PC_INC:   pc_nxt = pc + IW'(1);
            PC_TGT:   pc_nxt = target;
            default:  pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage of the 9-bit core; owns the PC, addresses the ROM and
// registers the fetched word (inst_out/inst_pc/inst_valid) for decode.
// Ports: CLK, Reset (async high), start, halt_in, stall, br_taken, br_abs,
// br_offset, jmp_target, inst_rom in; inst_addr, inst_out, inst_pc, inst_valid, done out.
// FETCH_PERF_CNT_EN adds saturating fetch_cnt/bubble_cnt outputs.
module inst_fetch
    import core_pkg::*;
#(
    parameter int            IW         = IW_DEF,
    parameter int            DW         = DW_DEF,
    parameter logic [IW-1:0] START_ADDR = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          start,
    input  logic          halt_in,
    input  logic          stall,
    input  logic          br_taken,
    input  logic          br_abs,
    input  logic [7:0]    br_offset,
    input  logic [IW-1:0] jmp_target,
    output logic [IW-1:0] inst_addr,
    input  logic [DW-1:0] inst_rom,
    output logic [DW-1:0] inst_out,
    output logic [IW-1:0] inst_pc,
    output logic          inst_valid,
    output logic          done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   bubble_cnt
`endif
);

    fetch_state_t  state, state_nxt;
    pc_sel_t       pc_sel;
    logic [IW-1:0] pc, pc_nxt;
    logic          run;
    logic          ld_fetch;
    logic          flush;
    logic          valid_nxt;
    logic          done_nxt;

    assign inst_addr = pc;
    assign run       = (state == RUN);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Priority: start > halt > stall > redirect > sequential.
    always_comb begin
        state_nxt = state;
        pc_sel    = PC_HOLD;
        ld_fetch  = 1'b0;
        flush     = 1'b0;
        valid_nxt = inst_valid;
        done_nxt  = done;
        priority case (1'b1)
            start: begin
                state_nxt = RUN;
                pc_sel    = PC_START;
                valid_nxt = 1'b0;
                done_nxt  = 1'b0;
            end
            run && halt_in && inst_valid: begin
                state_nxt = HALTED;
                valid_nxt = 1'b0;
                done_nxt  = 1'b1;
            end
            run && stall: begin
            end
            run && br_taken && inst_valid: begin
                pc_sel    = PC_TGT;
                valid_nxt = 1'b0;
                flush     = 1'b1;
            end
            run: begin
                pc_sel    = PC_INC;
                ld_fetch  = 1'b1;
                valid_nxt = 1'b1;
            end
            default: valid_nxt = 1'b0;
        endcase
    end

    pc_next #(
        .IW         (IW),
        .START_ADDR (START_ADDR)
    ) u_pc_next (
        .sel        (pc_sel),
        .pc         (pc),
        .inst_pc    (inst_pc),
        .br_abs     (br_abs),
        .br_offset  (br_offset),
        .jmp_target (jmp_target),
        .pc_nxt     (pc_nxt)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc         <= START_ADDR;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            inst_valid <= valid_nxt;
            done       <= done_nxt;
            if (ld_fetch) begin
                inst_out <= inst_rom;
                inst_pc  <= pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (start) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (ld_fetch && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (flush && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
